// File: rtl/vdf_dsp_pkg.sv
// vdf_dsp_pkg: shared widths and types for the DSP column-sum datapath
package vdf_dsp_pkg;
    localparam int LIMB_W = 17;
    localparam int COL_W  = 48;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} norm_state_t;
    typedef logic [LIMB_W-1:0] limb_t;
endpackage

// File: rtl/limb_carry_normaliser.sv
// limb_carry_normaliser: turns a stream of wide DSP column sums into carry-free limbs,
// flushing the residual carry as extra limbs after the last column.
module limb_carry_normaliser #(
    parameter int LIMB_W = vdf_dsp_pkg::LIMB_W,
    parameter int COL_W  = vdf_dsp_pkg::COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COL_W-1:0]  in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);
    import vdf_dsp_pkg::*;

    localparam int CARRY_W     = COL_W - LIMB_W + 1;
    localparam int FLUSH_LIMBS = (CARRY_W + LIMB_W - 1) / LIMB_W;
    localparam int FC_W        = FLUSH_LIMBS > 1 ? $clog2(FLUSH_LIMBS) : 1;

    norm_state_t        state, state_nxt;
    logic [CARRY_W-1:0] carry, carry_nxt;
    logic [FC_W-1:0]    fcnt, fcnt_nxt;
    logic [COL_W:0]     sum;
    logic [LIMB_W-1:0]  data_nxt;
    logic               last_nxt, valid_nxt, err_nxt;
    logic               out_free, take, fl_done, fl_load, fl_last;

    assign out_free = !out_valid || out_ready;
    assign in_ready = rst_n && state != FLUSH && out_free;
    assign take     = in_valid && in_ready;
    assign fl_done  = state == FLUSH && out_valid && out_ready && out_last;
    assign fl_load  = state == FLUSH && out_free && !fl_done;
    assign fl_last  = fcnt == FC_W'(FLUSH_LIMBS - 1);
    assign sum      = {1'b0, in_data} + {{LIMB_W{1'b0}}, in_sop ? {CARRY_W{1'b0}} : carry};

    always_comb begin
        state_nxt = state;
        carry_nxt = carry;
        fcnt_nxt  = fcnt;
        err_nxt   = err;
        valid_nxt = out_valid && !out_ready;
        data_nxt  = out_data;
        last_nxt  = out_last;
        if (take) begin
            data_nxt  = sum[LIMB_W-1:0];
            last_nxt  = 1'b0;
            valid_nxt = 1'b1;
            carry_nxt = sum[COL_W:LIMB_W];
            state_nxt = in_eop ? FLUSH : RUN;
            // sop is mandatory in IDLE and forbidden in RUN
            err_nxt   = err || ((state == IDLE) != in_sop);
        end else if (fl_load) begin
            data_nxt  = carry[LIMB_W-1:0];
            last_nxt  = fl_last;
            valid_nxt = 1'b1;
            carry_nxt = carry >> LIMB_W;
            fcnt_nxt  = fl_last ? '0 : fcnt + 1'b1;
        end else if (fl_done) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry     <= '0;
            fcnt      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            carry     <= carry_nxt;
            fcnt      <= fcnt_nxt;
            err       <= err_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_last  <= last_nxt;
        end
    end
endmodule
